// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [6:0] M_FUNCT7 = 7'h01;

   function automatic logic op_a_is_signed(input funct3_e f);
      return (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
   endfunction

   function automatic logic op_b_is_signed(input funct3_e f);
      return (f == MULH) || (f == DIV) || (f == REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply and restoring divide share
// one {hi, lo} accumulator pair. Next-state values are exported so the final
// step can be captured in the same edge that retires it.
module muldiv_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            is_div_i,
   input  logic [XLEN-1:0] mag_a_i,
   input  logic [XLEN-1:0] mag_b_i,
   output logic [XLEN-1:0] hi_nxt_o,
   output logic [XLEN-1:0] lo_nxt_o
);

   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q,  b_d;
   logic [XLEN:0]   add_s;
   logic [XLEN:0]   shl_s;
   logic [XLEN:0]   diff_s;

   // Multiply keeps the multiplier in lo and shifts the product in from hi;
   // divide shifts the dividend out of lo into the partial remainder in hi.
   always_comb begin
      add_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      shl_s  = {hi_q, lo_q[XLEN-1]};
      diff_s = shl_s - {1'b0, b_q};
      hi_d   = hi_q;
      lo_d   = lo_q;
      b_d    = b_q;
      if (load_i) begin
         hi_d = {XLEN{1'b0}};
         lo_d = mag_a_i;
         b_d  = mag_b_i;
      end else if (step_i) begin
         if (is_div_i) begin
            if (!diff_s[XLEN]) begin
               hi_d = diff_s[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               hi_d = shl_s[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            hi_d = add_s[XLEN:1];
            lo_d = {add_s[0], lo_q[XLEN-1:1]};
         end
      end else begin
         hi_d = hi_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= {XLEN{1'b0}};
         lo_q <= {XLEN{1'b0}};
         b_q  <= {XLEN{1'b0}};
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         b_q  <= b_d;
      end
   end

   assign hi_nxt_o = hi_d;
   assign lo_nxt_o = lo_d;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU: stalls the
// pipeline while iterating and presents one registered result to EX/MEM.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);
   import muldiv_pkg::*;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   funct3_e           f3_q, f3_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              valid_q, valid_d;

   funct3_e           f3_in_s;
   logic              sa_s, sb_s, neg_in_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s;
   logic              div_zero_s, div_ovf_s, special_s;
   logic [XLEN-1:0]   special_res_s;
   logic              load_s, step_s, stall_s;
   logic [XLEN-1:0]   hi_nxt_s, lo_nxt_s;
   logic [2*XLEN-1:0] prod_s, prod_fix_s;
   logic [XLEN-1:0]   div_mag_s, div_fix_s, final_s;

   localparam logic [XLEN-1:0] ONE_X     = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] INT_MIN_X = {1'b1, {(XLEN-1){1'b0}}};

   // Operand decode at issue: sign extraction, magnitudes and special divides.
   always_comb begin
      f3_in_s    = funct3_e'(funct3);
      sa_s       = op_a[XLEN-1] & op_a_is_signed(f3_in_s);
      sb_s       = op_b[XLEN-1] & op_b_is_signed(f3_in_s);
      mag_a_s    = sa_s ? (~op_a + ONE_X) : op_a;
      mag_b_s    = sb_s ? (~op_b + ONE_X) : op_b;
      neg_in_s   = funct3[1] & funct3[2] ? sa_s : (sa_s ^ sb_s);
      div_zero_s = (op_b == {XLEN{1'b0}});
      div_ovf_s  = ((f3_in_s == DIV) || (f3_in_s == REM)) &&
                   (op_a == INT_MIN_X) && (op_b == {XLEN{1'b1}});
      special_s  = funct3[2] & (div_zero_s | div_ovf_s);
      if (div_zero_s) begin
         special_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
      end else begin
         special_res_s = funct3[1] ? {XLEN{1'b0}} : op_a;
      end
   end

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load_s),
      .step_i   (step_s),
      .is_div_i (f3_q[2]),
      .mag_a_i  (mag_a_s),
      .mag_b_i  (mag_b_s),
      .hi_nxt_o (hi_nxt_s),
      .lo_nxt_o (lo_nxt_s)
   );

   // Sign correction on the post-final-step accumulators; the product is
   // negated across its full width before the half is selected.
   always_comb begin
      prod_s     = {hi_nxt_s, lo_nxt_s};
      prod_fix_s = neg_q ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
      div_mag_s  = f3_q[1] ? hi_nxt_s : lo_nxt_s;
      div_fix_s  = neg_q ? (~div_mag_s + ONE_X) : div_mag_s;
      case (f3_q)
         MUL:                 final_s = prod_fix_s[XLEN-1:0];
         MULH, MULHSU, MULHU: final_s = prod_fix_s[2*XLEN-1:XLEN];
         DIV, DIVU, REM, REMU: final_s = div_fix_s;
         default:             final_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM: flush overrides everything; DONE ignores the still-held start.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      result_d = result_q;
      valid_d  = 1'b0;
      load_s   = 1'b0;
      step_s   = 1'b0;
      stall_s  = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               stall_s = start;
               if (start) begin
                  f3_d  = f3_in_s;
                  neg_d = neg_in_s;
                  if (special_s) begin
                     state_d  = DONE;
                     result_d = special_res_s;
                     valid_d  = 1'b1;
                  end else begin
                     state_d = BUSY;
                     cnt_d   = CNT_W'(XLEN);
                     load_s  = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            BUSY: begin
               stall_s = 1'b1;
               step_s  = 1'b1;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d  = DONE;
                  result_d = final_s;
                  valid_d  = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         f3_q     <= MUL;
         neg_q    <= 1'b0;
         result_q <= {XLEN{1'b0}};
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign stall        = stall_s & ~rst;
   assign result_valid = valid_q;
   assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed, special-case, randomized,
// flush, asynchronous reset and back-to-back scenarios against a reference model.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        flush = 1'b0;
   logic        stall;
   logic        result_valid;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .funct3       (funct3),
      .op_a         (op_a),
      .op_b         (op_b),
      .flush        (flush),
      .stall        (stall),
      .result_valid (result_valid),
      .result       (result)
   );

   always #5 clk = ~clk;

   // Reference: full-width integer arithmetic on sign/zero-extended operands.
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, q;
      logic [63:0] p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = 32'd0;
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: if (b == 32'd0) r = 32'hFFFF_FFFF; else begin q = sa / sb; r = q[31:0]; end
         3'd5: if (b == 32'd0) r = 32'hFFFF_FFFF; else begin q = ua / ub; r = q[31:0]; end
         3'd6: if (b == 32'd0) r = a; else begin q = sa % sb; r = q[31:0]; end
         default: if (b == 32'd0) r = a; else begin q = ua % ub; r = q[31:0]; end
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 32'd0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   // Issues one operation and reports what the DUT did; callers judge it.
   task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit keep,
                           output int stalls, output bit tmo, output logic stall_done,
                           output logic [31:0] res, output logic rv_next, output logic [31:0] res_next);
      int n;
      start = 1'b1; funct3 = f; op_a = a; op_b = b;
      #1;
      stalls = 0; n = 0;
      while (result_valid !== 1'b1 && n < 80) begin
         if (stall === 1'b1) stalls++;
         @(negedge clk); #1;
         n++;
      end
      tmo = (n >= 80);
      stall_done = stall;
      res = result;
      if (!keep) start = 1'b0;
      @(negedge clk); #1;
      rv_next = result_valid;
      res_next = result;
   endtask

   task automatic test_reset;
      start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
      start = 1'b0;
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_idle_stall: got %b expected 0", stall); end
   endtask

   task automatic test_directed;
      logic [2:0]  tf [8] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] ta [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] tb [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] te [8] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      int st; bit tmo; logic sd, rvn; logic [31:0] r, rn;
      for (int i = 0; i < 8; i++) begin
         drive_op(tf[i], ta[i], tb[i], 1'b0, st, tmo, sd, r, rvn, rn);
         checks++; if (tmo || r !== te[i]) begin errors++; $display("FAIL directed_%0d_result: got %h expected %h (timeout=%0d)", i, r, te[i], tmo); end
         checks++; if (st != 33) begin errors++; $display("FAIL directed_%0d_stalls: got %0d expected 33", i, st); end
         checks++; if (sd !== 1'b0) begin errors++; $display("FAIL directed_%0d_done_stall: got %b expected 0", i, sd); end
         checks++; if (rvn !== 1'b0 || rn !== te[i]) begin errors++; $display("FAIL directed_%0d_hold: got valid=%b result=%h expected valid=0 result=%h", i, rvn, rn, te[i]); end
      end
   endtask

   task automatic test_special;
      logic [2:0]  tf [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] ta [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] tb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] te [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int st; bit tmo; logic sd, rvn; logic [31:0] r, rn;
      for (int i = 0; i < 4; i++) begin
         drive_op(tf[i], ta[i], tb[i], 1'b0, st, tmo, sd, r, rvn, rn);
         checks++; if (tmo || r !== te[i]) begin errors++; $display("FAIL special_%0d_result: got %h expected %h", i, r, te[i]); end
         checks++; if (st != 1) begin errors++; $display("FAIL special_%0d_stalls: got %0d expected 1", i, st); end
         checks++; if (rvn !== 1'b0) begin errors++; $display("FAIL special_%0d_valid_drop: got %b expected 0", i, rvn); end
      end
   endtask

   task automatic test_random;
      logic [2:0] f; logic [31:0] a, b, e;
      int st, el; bit tmo; logic sd, rvn; logic [31:0] r, rn;
      for (int i = 0; i < 20; i++) begin
         f = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 300));
            default: b = 32'($urandom);
         endcase
         e = ref_op(f, a, b);
         el = ref_lat(f, a, b);
         drive_op(f, a, b, 1'b0, st, tmo, sd, r, rvn, rn);
         checks++; if (tmo || r !== e) begin errors++; $display("FAIL random_%0d_result: f3=%0d a=%h b=%h got %h expected %h", i, f, a, b, r, e); end
         checks++; if (st != el) begin errors++; $display("FAIL random_%0d_stalls: got %0d expected %0d", i, st, el); end
      end
   endtask

   task automatic test_flush;
      int spurious, st; bit tmo; logic sd, rvn; logic [31:0] r, rn;
      start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b expected 0", stall); end
      @(negedge clk); #1;
      flush = 1'b0; op_a = 32'h1234; op_b = 32'h5678;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_start_stall: got %b expected 1", stall); end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); #1;
      end
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_busy_stall: got %b expected 0", stall); end
      @(negedge clk); #1;
      flush = 1'b0; start = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_after: got stall=%b valid=%b expected 0/0", stall, result_valid); end
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (result_valid !== 1'b0) spurious++;
      end
      checks++; if (spurious != 0) begin errors++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", spurious); end
      drive_op(3'd0, 32'd3, 32'd4, 1'b0, st, tmo, sd, r, rvn, rn);
      checks++; if (tmo || r !== 32'd12) begin errors++; $display("FAIL flush_followup_result: got %h expected 0000000c", r); end
      checks++; if (st != 33) begin errors++; $display("FAIL flush_followup_stalls: got %0d expected 33", st); end
   endtask

   task automatic test_async_reset;
      int st; bit tmo; logic sd, rvn; logic [31:0] r, rn;
      start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
      end
      start = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
         errors++; $display("FAIL async_reset: got stall=%b valid=%b result=%h expected 0/0/00000000", stall, result_valid, result);
      end
      @(negedge clk); rst = 1'b0; #1;
      drive_op(3'd5, 32'd1000, 32'd3, 1'b0, st, tmo, sd, r, rvn, rn);
      checks++; if (tmo || r !== 32'd333 || st != 33) begin errors++; $display("FAIL async_reset_recover: got result=%h stalls=%0d expected 0000014d/33", r, st); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] e1, e2;
      int st1, st2; bit t1, t2; logic sd1, sd2, rv1, rv2; logic [31:0] r1, r2, rn1, rn2;
      e1 = ref_op(3'd5, 32'd77777, 32'd13);
      e2 = ref_op(3'd5, 32'hDEAD_BEEF, 32'd1000);
      drive_op(3'd5, 32'd77777, 32'd13, 1'b1, st1, t1, sd1, r1, rv1, rn1);
      drive_op(3'd5, 32'hDEAD_BEEF, 32'd1000, 1'b0, st2, t2, sd2, r2, rv2, rn2);
      checks++; if (t1 || r1 !== e1) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", r1, e1); end
      checks++; if (sd1 !== 1'b0 || rv1 !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle: got stall=%b next_valid=%b expected 0/0", sd1, rv1); end
      checks++; if (t2 || r2 !== e2) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", r2, e2); end
      checks++; if (st2 != 33) begin errors++; $display("FAIL b2b_gap: got %0d stall cycles expected 33", st2); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_random();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
